// File: rtl/mult_div_unit.sv
// mult_div_unit: MIPS-style HI/LO multiply/divide unit with fixed-latency busy window
// Ports: clk, reset (sync, active-high); op selects none/MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO;
// rs_val/rt_val are the forwarded operands; busy flags a multiply/divide in flight;
// stall_req goes to the hazard unit; hi_o/lo_o are the architectural HI/LO registers;
// mf_data is the combinational MFHI/MFLO read data.
module mult_div_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic [31:0] mf_data
);
  logic [3:0]  r_cnt;
  logic [63:0] r_res;
  logic        r_wr;
  logic [31:0] r_hi, r_lo;
  logic        w_busy, w_start, w_mul, w_na, w_nb;
  logic [31:0] w_ua, w_ub, w_den, w_mq, w_mr, w_q, w_r;
  logic [63:0] w_smul, w_umul, w_res;
  assign w_busy  = r_cnt != 4'd0;
  assign w_start = !w_busy && op >= 4'd1 && op <= 4'd4;
  assign w_mul   = op == 4'd1 || op == 4'd2;
  // Low 64 bits of a product of sign-extended operands equal the signed 32x32 product.
  assign w_smul = {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val};
  assign w_umul = {32'd0, rs_val} * {32'd0, rt_val};
  // One magnitude divider serves both DIV and DIVU; signs are reapplied afterwards,
  // which also yields 0x80000000 for the 0x80000000 / -1 overflow case.
  assign w_na  = op == 4'd3 && rs_val[31];
  assign w_nb  = op == 4'd3 && rt_val[31];
  assign w_ua  = w_na ? -rs_val : rs_val;
  assign w_ub  = w_nb ? -rt_val : rt_val;
  assign w_den = w_ub == 32'd0 ? 32'd1 : w_ub;
  assign w_mq  = w_ua / w_den;
  assign w_mr  = w_ua % w_den;
  assign w_q   = (w_na ^ w_nb) ? -w_mq : w_mq;
  assign w_r   = w_na ? -w_mr : w_mr;
  always_comb begin
    w_res = op == 4'd1 ? w_smul : op == 4'd2 ? w_umul : {w_r, w_q};
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= 4'd0;
      r_res <= 64'd0;
      r_wr  <= 1'b0;
      r_hi  <= 32'd0;
      r_lo  <= 32'd0;
    end else if (w_start) begin
      r_cnt <= w_mul ? 4'd5 : 4'd10;
      r_res <= w_res;
      r_wr  <= w_mul || rt_val != 32'd0;
    end else if (w_busy) begin
      r_cnt <= r_cnt - 4'd1;
      if (r_cnt == 4'd1 && r_wr) {r_hi, r_lo} <= r_res;
    end else if (op == 4'd5) begin
      r_hi <= rs_val;
    end else if (op == 4'd6) begin
      r_lo <= rs_val;
    end
  end
  assign busy      = w_busy;
  assign stall_req = w_busy ? (op >= 4'd1 && op <= 4'd8) : w_start;
  assign hi_o      = r_hi;
  assign lo_o      = r_lo;
  assign mf_data   = op == 4'd7 ? r_hi : op == 4'd8 ? r_lo : 32'd0;
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed and random checks of mult_div_unit against an arithmetic model
module tb_mult_div_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  op;
  logic [31:0] rs_val, rt_val;
  logic        busy, stall_req;
  logic [31:0] hi_o, lo_o, mf_data;
  int          n_chk = 0;
  int          n_err = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  mult_div_unit dut (
    .clk(clk), .reset(reset), .op(op), .rs_val(rs_val), .rt_val(rt_val),
    .busy(busy), .stall_req(stall_req), .hi_o(hi_o), .lo_o(lo_o), .mf_data(mf_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, q, r;
    longint unsigned pu;
    if (o == 4'd1) begin
      q = longint'($signed(a)) * longint'($signed(b));
      m_hi = q[63:32];
      m_lo = q[31:0];
    end else if (o == 4'd2) begin
      pu = 64'(a) * 64'(b);
      m_hi = pu[63:32];
      m_lo = pu[31:0];
    end else if (o == 4'd3 && b != 32'd0) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q = sa / sb;
      r = sa % sb;
      m_lo = q[31:0];
      m_hi = r[31:0];
    end else if (o == 4'd4 && b != 32'd0) begin
      m_lo = a / b;
      m_hi = a % b;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                     input logic [3:0] bop, input logic [31:0] bval, input string tag);
    int n;
    op = o; rs_val = a; rt_val = b;
    #1;
    chk({tag, " start stall"}, 32'(stall_req), 32'd1);
    tick();
    op = bop; rs_val = bval; rt_val = $urandom;
    n = 0;
    while (n < 20) begin
      #1;
      if (busy !== 1'b1) break;
      chk({tag, " busy stall"}, 32'(stall_req), 32'(bop >= 4'd1 && bop <= 4'd8));
      if (bop == 4'd7) chk({tag, " mfhi busy"}, mf_data, m_hi);
      if (bop == 4'd8) chk({tag, " mflo busy"}, mf_data, m_lo);
      n++;
      tick();
      rt_val = $urandom;
      if (bop == 4'd0) rs_val = $urandom;
    end
    op = 4'd0;
    #1;
    chk({tag, " busy cycles"}, 32'(n), (o <= 4'd2) ? 32'd5 : 32'd10);
    model(o, a, b);
    chk({tag, " hi"}, hi_o, m_hi);
    chk({tag, " lo"}, lo_o, m_lo);
    op = 4'd8;
    #1;
    chk({tag, " mflo after"}, mf_data, m_lo);
    op = 4'd0;
  endtask

  task automatic mt(input logic [3:0] o, input logic [31:0] v, input string tag);
    op = o; rs_val = v;
    #1;
    chk({tag, " stall"}, 32'(stall_req), 32'd0);
    tick();
    op = 4'd0;
    if (o == 4'd5) m_hi = v; else m_lo = v;
    chk({tag, " busy"}, 32'(busy), 32'd0);
    chk({tag, " hi"}, hi_o, m_hi);
    chk({tag, " lo"}, lo_o, m_lo);
  endtask

  initial begin
    logic [3:0]  o, bop;
    logic [31:0] a, b;
    reset = 1'b1; op = 4'd0; rs_val = 32'd0; rt_val = 32'd0;
    repeat (2) tick();
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset hi", hi_o, 32'd0);
    chk("reset lo", lo_o, 32'd0);
    chk("reset stall", 32'(stall_req), 32'd0);
    reset = 1'b0;
    run(4'd1, 32'hFFFFFFFE, 32'd3, 4'd6, 32'h0000AAAA, "mult+mtlo");
    chk("mult hi const", hi_o, 32'hFFFFFFFF);
    chk("mult lo const", lo_o, 32'hFFFFFFFA);
    mt(4'd5, 32'h00000042, "mthi pre");
    run(4'd2, 32'hFFFFFFFE, 32'd3, 4'd7, 32'd0, "multu+mfhi");
    chk("multu hi const", hi_o, 32'h00000002);
    chk("multu lo const", lo_o, 32'hFFFFFFFA);
    run(4'd3, 32'hFFFFFFF9, 32'd2, 4'd8, 32'd0, "div-7/2");
    chk("div lo const", lo_o, 32'hFFFFFFFD);
    chk("div hi const", hi_o, 32'hFFFFFFFF);
    run(4'd3, 32'h80000000, 32'hFFFFFFFF, 4'd0, 32'd0, "div ovf");
    chk("div ovf lo const", lo_o, 32'h80000000);
    chk("div ovf hi const", hi_o, 32'h00000000);
    mt(4'd5, 32'h00001234, "mthi");
    mt(4'd6, 32'h00005678, "mtlo");
    run(4'd4, 32'd77, 32'd0, 4'd0, 32'd0, "divu by0");
    chk("divu by0 hi const", hi_o, 32'h00001234);
    chk("divu by0 lo const", lo_o, 32'h00005678);
    run(4'd3, 32'd100, 32'd7, 4'd1, 32'd9, "div+mult held");
    run(4'd1, 32'd9, 32'd11, 4'd0, 32'd0, "mult replay");
    op = 4'd3; rs_val = 32'd1000; rt_val = 32'd3;
    tick();
    op = 4'd0;
    tick();
    tick();
    reset = 1'b1; op = 4'd1;
    tick();
    m_hi = 32'd0; m_lo = 32'd0;
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort hi", hi_o, 32'd0);
    chk("abort lo", lo_o, 32'd0);
    reset = 1'b0;
    mt(4'd5, 32'h0000CAFE, "post-reset mthi");
    repeat (12) tick();
    chk("no late commit hi", hi_o, 32'h0000CAFE);
    chk("no late commit lo", lo_o, 32'd0);
    chk("no late busy", 32'(busy), 32'd0);
    for (int i = 0; i < 30; i++) begin
      o = 4'($urandom_range(1, 6));
      a = $urandom;
      b = ($urandom_range(0, 5) == 0) ? 32'd0 : ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 9)) : $urandom;
      bop = 4'($urandom_range(0, 8));
      if (o <= 4'd4) run(o, a, b, bop, $urandom, "rand");
      else mt(o, a, "rand mt");
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
